// File: rtl/store_drain_arbiter.sv
// Drain queue for evicted stores plus single-port cache arbiter between drains and loads.
// Loads win unless they hit a queued store address or have starved the queue too long.
module store_drain_arbiter #(
    parameter int LINE_SIZE    = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       DrainValid,
    input  logic [LINE_SIZE-1:0]       DrainData,
    input  logic [LINE_SIZE-1:0]       DrainAddress,
    input  logic                       DrainByte,
    output logic                       DrainStall,
    input  logic                       LoadReq,
    input  logic [LINE_SIZE-1:0]       LoadAddress,
    output logic                       LoadGrant,
    output logic                       CacheReq,
    output logic                       CacheWe,
    output logic [LINE_SIZE-1:0]       CacheAddress,
    output logic [LINE_SIZE-1:0]       CacheData,
    output logic                       CacheByte,
    input  logic                       CacheReady,
    output logic [$clog2(DEPTH+1)-1:0] QueueCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_LD = 2'd1;
    localparam logic [1:0] ST_BUSY_ST = 2'd2;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [LINE_SIZE-1:0] r_q_addr [DEPTH];
    logic [LINE_SIZE-1:0] r_q_data [DEPTH];
    logic [DEPTH-1:0]     r_q_byte;
    logic [DEPTH-1:0]     r_q_valid;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [SW-1:0]        r_starve;
    logic [1:0]           r_state;

    logic                 r_cache_req;
    logic                 r_cache_we;
    logic [LINE_SIZE-1:0] r_cache_addr;
    logic [LINE_SIZE-1:0] r_cache_data;
    logic                 r_cache_byte;
    logic                 r_load_grant;

    logic w_push;
    logic w_pop;
    logic w_q_empty;
    logic w_hazard;
    logic w_issue_ld;
    logic w_issue_st;

    assign DrainStall   = (r_count == FULL_COUNT);
    assign QueueCount   = r_count;
    assign CacheReq     = r_cache_req;
    assign CacheWe      = r_cache_we;
    assign CacheAddress = r_cache_addr;
    assign CacheData    = r_cache_data;
    assign CacheByte    = r_cache_byte;
    assign LoadGrant    = r_load_grant;

    assign w_push     = DrainValid && !DrainStall;
    assign w_pop      = (r_state == ST_BUSY_ST) && CacheReady;
    assign w_q_empty  = (r_count == {CW{1'b0}});
    assign w_issue_ld = (r_state == ST_IDLE) && LoadReq && !w_hazard &&
                        (w_q_empty || (r_starve < STARVE_MAX));
    assign w_issue_st = (r_state == ST_IDLE) && !w_issue_ld && !w_q_empty;

    // RAW hazard: any valid entry, including the head currently being written
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hazard = w_hazard | (r_q_valid[i] && (r_q_addr[i] == LoadAddress));
        end
    end

    // Circular drain queue storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_addr[i] <= {LINE_SIZE{1'b0}};
                r_q_data[i] <= {LINE_SIZE{1'b0}};
            end
            r_q_byte  <= {DEPTH{1'b0}};
            r_q_valid <= {DEPTH{1'b0}};
            r_wr_ptr  <= {PW{1'b0}};
            r_rd_ptr  <= {PW{1'b0}};
            r_count   <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_q_addr[r_wr_ptr]  <= DrainAddress;
                r_q_data[r_wr_ptr]  <= DrainData;
                r_q_byte[r_wr_ptr]  <= DrainByte;
                r_q_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr            <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_q_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Consecutive-load counter that eventually forces a drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= {SW{1'b0}};
        end else if (w_q_empty || w_issue_st) begin
            r_starve <= {SW{1'b0}};
        end else if (w_issue_ld && (r_starve < STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Arbitration FSM driving the registered cache port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cache_req  <= 1'b0;
            r_cache_we   <= 1'b0;
            r_cache_addr <= {LINE_SIZE{1'b0}};
            r_cache_data <= {LINE_SIZE{1'b0}};
            r_cache_byte <= 1'b0;
            r_load_grant <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_load_grant <= 1'b0;
                    if (w_issue_ld) begin
                        r_state      <= ST_BUSY_LD;
                        r_cache_req  <= 1'b1;
                        r_cache_we   <= 1'b0;
                        r_cache_addr <= LoadAddress;
                        r_cache_byte <= 1'b0;
                    end else if (w_issue_st) begin
                        r_state      <= ST_BUSY_ST;
                        r_cache_req  <= 1'b1;
                        r_cache_we   <= 1'b1;
                        r_cache_addr <= r_q_addr[r_rd_ptr];
                        r_cache_data <= r_q_data[r_rd_ptr];
                        r_cache_byte <= r_q_byte[r_rd_ptr];
                    end else begin
                        r_cache_req  <= 1'b0;
                    end
                end
                ST_BUSY_LD: begin
                    if (CacheReady) begin
                        r_state      <= ST_IDLE;
                        r_cache_req  <= 1'b0;
                        r_load_grant <= 1'b1;
                    end else begin
                        r_load_grant <= 1'b0;
                    end
                end
                ST_BUSY_ST: begin
                    r_load_grant <= 1'b0;
                    if (CacheReady) begin
                        r_state     <= ST_IDLE;
                        r_cache_req <= 1'b0;
                    end else begin
                        r_cache_req <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cache_req  <= 1'b0;
                    r_load_grant <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_drain_arbiter.sv
// Directed self-checking bench for store_drain_arbiter (DEPTH=4, STARVE_LIMIT=3).
module tb_store_drain_arbiter;
    logic        clk;
    logic        rst;
    logic        DrainValid;
    logic [31:0] DrainData;
    logic [31:0] DrainAddress;
    logic        DrainByte;
    logic        DrainStall;
    logic        LoadReq;
    logic [31:0] LoadAddress;
    logic        LoadGrant;
    logic        CacheReq;
    logic        CacheWe;
    logic [31:0] CacheAddress;
    logic [31:0] CacheData;
    logic        CacheByte;
    logic        CacheReady;
    logic [2:0]  QueueCount;

    int checks;
    int errors;

    store_drain_arbiter #(.LINE_SIZE(32), .DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .DrainValid(DrainValid), .DrainData(DrainData), .DrainAddress(DrainAddress),
        .DrainByte(DrainByte), .DrainStall(DrainStall),
        .LoadReq(LoadReq), .LoadAddress(LoadAddress), .LoadGrant(LoadGrant),
        .CacheReq(CacheReq), .CacheWe(CacheWe), .CacheAddress(CacheAddress),
        .CacheData(CacheData), .CacheByte(CacheByte), .CacheReady(CacheReady),
        .QueueCount(QueueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_push(input logic [31:0] a, input logic b);
        @(negedge clk);
        DrainValid   = 1'b1;
        DrainAddress = a;
        DrainData    = 32'hD000_0000 | a;
        DrainByte    = b;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; DrainValid = 1'b0; DrainData = 32'd0; DrainAddress = 32'd0;
        DrainByte = 1'b0; LoadReq = 1'b0; LoadAddress = 32'd0; CacheReady = 1'b0;
        idle_cycles(2);
        checks++; if (CacheReq !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", CacheReq); end
        checks++; if (LoadGrant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b exp 0", LoadGrant); end
        checks++; if (DrainStall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", DrainStall); end
        checks++; if (QueueCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", QueueCount); end
        checks++; if (CacheAddress !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", CacheAddress); end
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_fill_and_order;
        logic [31:0] got_a [5];
        logic [31:0] got_d [5];
        logic        got_b [5];
        logic [31:0] exp_a [5];
        int  n;
        bit  acc;
        bit  stall_seen_low;
        exp_a[0] = 32'h10; exp_a[1] = 32'h14; exp_a[2] = 32'h18; exp_a[3] = 32'h1C; exp_a[4] = 32'h20;
        for (int i = 0; i < 5; i++) begin got_a[i] = 32'd0; got_d[i] = 32'd0; got_b[i] = 1'b0; end
        CacheReady = 1'b0;
        for (int i = 0; i < 5; i++) drive_push(exp_a[i], (i == 1));
        checks++; if (QueueCount !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", QueueCount); end
        checks++; if (DrainStall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", DrainStall); end
        checks++; if (CacheReq !== 1'b1 || CacheWe !== 1'b1 || CacheAddress !== 32'h10) begin
            errors++; $display("FAIL head_held got req=%b we=%b addr=%h exp 1 1 00000010", CacheReq, CacheWe, CacheAddress); end
        idle_cycles(1);
        checks++; if (QueueCount !== 3'd4) begin errors++; $display("FAIL fifth_held got %0d exp 4", QueueCount); end
        got_a[0] = CacheAddress; got_d[0] = CacheData; got_b[0] = CacheByte;
        n = 1; acc = 1'b0; stall_seen_low = 1'b0;
        CacheReady = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (acc) DrainValid = 1'b0;
            if (CacheReq && CacheWe) begin
                got_a[n] = CacheAddress; got_d[n] = CacheData; got_b[n] = CacheByte; n++;
            end
            if (DrainValid && !DrainStall && !acc) begin
                acc = 1'b1;
                stall_seen_low = 1'b1;
                checks++; if (n < 1) begin errors++; $display("FAIL fifth_before_pop got pops=%0d exp >=1", n); end
            end
        end
        DrainValid = 1'b0;
        checks++; if (!stall_seen_low) begin errors++; $display("FAIL fifth_accept got none exp accepted"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got_a[i] !== exp_a[i] || got_d[i] !== (32'hD000_0000 | exp_a[i])) begin
                errors++; $display("FAIL store_order[%0d] got %h/%h exp %h/%h", i, got_a[i], got_d[i], exp_a[i], 32'hD000_0000 | exp_a[i]); end
        end
        checks++; if (got_b[1] !== 1'b1 || got_b[0] !== 1'b0) begin
            errors++; $display("FAIL byte_flag got %b%b exp 10", got_b[1], got_b[0]); end
        idle_cycles(3);
        checks++; if (QueueCount !== 3'd0 || CacheReq !== 1'b0) begin
            errors++; $display("FAIL drained got count=%0d req=%b exp 0 0", QueueCount, CacheReq); end
    endtask

    task automatic test_load;
        CacheReady = 1'b1;
        @(negedge clk);
        LoadReq = 1'b1; LoadAddress = 32'h40;
        @(negedge clk);
        checks++; if (CacheReq !== 1'b1 || CacheWe !== 1'b0 || CacheAddress !== 32'h40) begin
            errors++; $display("FAIL load_issue got req=%b we=%b addr=%h exp 1 0 00000040", CacheReq, CacheWe, CacheAddress); end
        checks++; if (LoadGrant !== 1'b0) begin errors++; $display("FAIL load_grant_early got %b exp 0", LoadGrant); end
        @(negedge clk);
        checks++; if (LoadGrant !== 1'b1 || CacheReq !== 1'b0) begin
            errors++; $display("FAIL load_grant got grant=%b req=%b exp 1 0", LoadGrant, CacheReq); end
        LoadReq = 1'b0;
        @(negedge clk);
        checks++; if (LoadGrant !== 1'b0 || CacheReq !== 1'b0) begin
            errors++; $display("FAIL load_grant_pulse got grant=%b req=%b exp 0 0", LoadGrant, CacheReq); end
    endtask

    task automatic test_raw_hazard;
        CacheReady = 1'b0;
        drive_push(32'h40, 1'b0);
        @(negedge clk);
        DrainValid = 1'b0; LoadReq = 1'b1; LoadAddress = 32'h40;
        @(negedge clk);
        checks++; if (CacheReq !== 1'b1 || CacheWe !== 1'b1 || CacheAddress !== 32'h40) begin
            errors++; $display("FAIL raw_store_first got req=%b we=%b addr=%h exp 1 1 00000040", CacheReq, CacheWe, CacheAddress); end
        @(negedge clk);
        checks++; if (CacheWe !== 1'b1 || QueueCount !== 3'd1) begin
            errors++; $display("FAIL raw_store_held got we=%b count=%0d exp 1 1", CacheWe, QueueCount); end
        CacheReady = 1'b1;
        @(negedge clk);
        checks++; if (CacheReq !== 1'b0 || QueueCount !== 3'd0) begin
            errors++; $display("FAIL raw_pop got req=%b count=%0d exp 0 0", CacheReq, QueueCount); end
        @(negedge clk);
        checks++; if (CacheReq !== 1'b1 || CacheWe !== 1'b0 || CacheAddress !== 32'h40) begin
            errors++; $display("FAIL raw_load_after got req=%b we=%b addr=%h exp 1 0 00000040", CacheReq, CacheWe, CacheAddress); end
        @(negedge clk);
        checks++; if (LoadGrant !== 1'b1) begin errors++; $display("FAIL raw_grant got %b exp 1", LoadGrant); end
        LoadReq = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_starvation;
        int grants;
        int grants_before;
        bit store_seen;
        bit load_after;
        logic [31:0] store_addr;
        grants = 0; grants_before = -1; store_seen = 1'b0; load_after = 1'b0; store_addr = 32'd0;
        CacheReady = 1'b1;
        drive_push(32'h80, 1'b0);
        @(negedge clk);
        DrainValid = 1'b0; LoadReq = 1'b1; LoadAddress = 32'h20;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (LoadGrant && !store_seen) grants++;
            if (CacheReq && CacheWe && !store_seen) begin
                store_seen = 1'b1; store_addr = CacheAddress; grants_before = grants;
            end
            if (CacheReq && !CacheWe && store_seen && CacheAddress == 32'h20) load_after = 1'b1;
        end
        LoadReq = 1'b0;
        checks++; if (grants_before != 3) begin errors++; $display("FAIL starve_grants got %0d exp 3", grants_before); end
        checks++; if (store_addr !== 32'h80) begin errors++; $display("FAIL starve_store got %h exp 00000080", store_addr); end
        checks++; if (!load_after) begin errors++; $display("FAIL starve_resume got 0 exp 1"); end
        idle_cycles(4);
        checks++; if (QueueCount !== 3'd0 || CacheReq !== 1'b0) begin
            errors++; $display("FAIL starve_idle got count=%0d req=%b exp 0 0", QueueCount, CacheReq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got [2];
        int n;
        got[0] = 32'd0; got[1] = 32'd0; n = 0;
        CacheReady = 1'b0;
        drive_push(32'h100, 1'b0);
        drive_push(32'h104, 1'b0);
        drive_push(32'h108, 1'b0);
        checks++; if (QueueCount !== 3'd2 || CacheAddress !== 32'h100 || CacheReq !== 1'b1) begin
            errors++; $display("FAIL b2b_pre got count=%0d addr=%h req=%b exp 2 00000100 1", QueueCount, CacheAddress, CacheReq); end
        CacheReady = 1'b1;
        @(negedge clk);
        DrainValid = 1'b0;
        checks++; if (QueueCount !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", QueueCount); end
        for (int cyc = 0; cyc < 10 && n < 2; cyc++) begin
            @(negedge clk);
            if (CacheReq && CacheWe) begin got[n] = CacheAddress; n++; end
        end
        checks++; if (got[0] !== 32'h104 || got[1] !== 32'h108) begin
            errors++; $display("FAIL b2b_order got %h %h exp 00000104 00000108", got[0], got[1]); end
        idle_cycles(2);
    endtask

    task automatic test_reset_midrun;
        CacheReady = 1'b0;
        for (int i = 0; i < 4; i++) drive_push(32'h200 + 32'(i * 4), 1'b0);
        @(negedge clk);
        DrainValid = 1'b0;
        checks++; if (DrainStall !== 1'b1 || CacheReq !== 1'b1) begin
            errors++; $display("FAIL mid_pre got stall=%b req=%b exp 1 1", DrainStall, CacheReq); end
        #2 rst = 1'b1;
        #1;
        checks++; if (CacheReq !== 1'b0 || LoadGrant !== 1'b0 || DrainStall !== 1'b0 || QueueCount !== 3'd0) begin
            errors++; $display("FAIL mid_reset got req=%b grant=%b stall=%b count=%0d exp 0 0 0 0",
                               CacheReq, LoadGrant, DrainStall, QueueCount); end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
        checks++; if (CacheReq !== 1'b0 || QueueCount !== 3'd0) begin
            errors++; $display("FAIL mid_discard got req=%b count=%0d exp 0 0", CacheReq, QueueCount); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_fill_and_order;
        test_load;
        test_raw_hazard;
        test_starvation;
        test_back_to_back;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
